// File: rtl/memory_bus_arbiter.sv
// memory_bus_arbiter
//   Shares one memory port between two managers (m0, m1). One access is
//   outstanding at a time; the owning manager's request is forwarded
//   combinationally to memory, and the memory's completion is routed back to
//   that manager only.
//
// Handshake: a manager raises read_request or write_request together with
//   address/data/strobe and holds all of them stable until it samples its
//   matching response high on a rising clock edge. The response is a single
//   cycle wide. Memory follows the same rule on the s_* side. After every
//   completion the arbiter spends one cycle in IDLE, which absorbs the
//   memory's still-high registered response so it cannot complete the next
//   owner's access.
//
// Ports:
//   clock, reset            rising-edge clock, synchronous active-high reset
//   m{0,1}_*                manager request side (address, data, strobe,
//                           read/write request in; read data and
//                           read/write response out)
//   s_*                     memory side (forwarded request out, data and
//                           responses in)
//   timeout_pulse           one cycle high when an access is force-completed
//   grant                   one-hot current owner (01 = m0, 10 = m1)
//   debug_state             raw FSM state for observation

module memory_bus_arbiter #(
  parameter int FIXED_PRIORITY = 0,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] m0_rw_address,
  output logic [31:0] m0_read_data,
  input  logic        m0_read_request,
  output logic        m0_read_response,
  input  logic [31:0] m0_write_data,
  input  logic [3:0]  m0_write_strobe,
  input  logic        m0_write_request,
  output logic        m0_write_response,
  input  logic [31:0] m1_rw_address,
  output logic [31:0] m1_read_data,
  input  logic        m1_read_request,
  output logic        m1_read_response,
  input  logic [31:0] m1_write_data,
  input  logic [3:0]  m1_write_strobe,
  input  logic        m1_write_request,
  output logic        m1_write_response,
  output logic [31:0] s_rw_address,
  output logic [31:0] s_write_data,
  output logic [3:0]  s_write_strobe,
  output logic        s_read_request,
  output logic        s_write_request,
  input  logic [31:0] s_read_data,
  input  logic        s_read_response,
  input  logic        s_write_response,
  output logic        timeout_pulse,
  output logic [1:0]  grant,
  output logic [1:0]  debug_state
);

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    BUSY_M0 = 2'b01,
    BUSY_M1 = 2'b10
  } state_t;

  localparam logic [15:0] TIMEOUT_LIMIT = 16'(TIMEOUT_CYCLES);

  state_t      state;
  logic        last_grant;     // 0 = m0 granted last, 1 = m1 granted last
  logic [15:0] timeout_count;

  logic        active;
  logic        owner_m1;
  logic        own_rreq;
  logic        own_wreq;
  logic        own_pending;
  logic [31:0] own_addr;
  logic [31:0] own_wdata;
  logic [3:0]  own_strb;
  logic        completion;
  logic        timeout_hit;
  logic        rd_resp;
  logic        wr_resp;
  logic [31:0] rd_data;
  logic        m0_pending;
  logic        m1_pending;
  logic        tie_pick_m1;

  always_comb begin
    // Reset gates every output so the bus is quiet while reset is held,
    // even during the cycle before the state register returns to IDLE.
    active      = (state != IDLE) && !reset;
    owner_m1    = (state == BUSY_M1);
    own_rreq    = owner_m1 ? m1_read_request  : m0_read_request;
    own_wreq    = owner_m1 ? m1_write_request : m0_write_request;
    own_addr    = owner_m1 ? m1_rw_address    : m0_rw_address;
    own_wdata   = owner_m1 ? m1_write_data    : m0_write_data;
    own_strb    = owner_m1 ? m1_write_strobe  : m0_write_strobe;
    own_pending = own_rreq || own_wreq;

    // Completion is judged against the owner's own request lines so that it
    // does not depend on the forwarded requests, which timeout suppresses.
    completion  = active && ((own_rreq && s_read_response) ||
                             (own_wreq && s_write_response));
    timeout_hit = active && own_pending && !completion &&
                  (timeout_count == TIMEOUT_LIMIT);

    // Responses only go back for a request that is still held; a dropped
    // request never receives a late response.
    rd_resp = active && own_rreq && (s_read_response  || timeout_hit);
    wr_resp = active && own_wreq && (s_write_response || timeout_hit);
    rd_data = (active && !timeout_hit) ? s_read_data : 32'h0;

    m0_pending  = m0_read_request || m0_write_request;
    m1_pending  = m1_read_request || m1_write_request;
    tie_pick_m1 = (FIXED_PRIORITY != 0) ? 1'b0 : !last_grant;
  end

  assign s_rw_address      = active ? own_addr  : 32'h0;
  assign s_write_data      = active ? own_wdata : 32'h0;
  assign s_write_strobe    = active ? own_strb  : 4'h0;
  assign s_read_request    = active && own_rreq && !timeout_hit;
  assign s_write_request   = active && own_wreq && !timeout_hit;

  assign m0_read_response  = rd_resp && !owner_m1;
  assign m0_write_response = wr_resp && !owner_m1;
  assign m0_read_data      = owner_m1 ? 32'h0 : rd_data;
  assign m1_read_response  = rd_resp && owner_m1;
  assign m1_write_response = wr_resp && owner_m1;
  assign m1_read_data      = owner_m1 ? rd_data : 32'h0;

  assign timeout_pulse     = timeout_hit;
  assign grant             = {active && owner_m1, active && !owner_m1};
  assign debug_state       = state;

  always_ff @(posedge clock) begin
    if (reset) begin
      state         <= IDLE;
      last_grant    <= 1'b1;
      timeout_count <= 16'h0;
    end else begin
      case (state)
        IDLE: begin
          timeout_count <= 16'h0;
          if (m0_pending && m1_pending) begin
            state      <= tie_pick_m1 ? BUSY_M1 : BUSY_M0;
            last_grant <= tie_pick_m1;
          end else if (m0_pending) begin
            state      <= BUSY_M0;
            last_grant <= 1'b0;
          end else if (m1_pending) begin
            state      <= BUSY_M1;
            last_grant <= 1'b1;
          end
        end
        BUSY_M0, BUSY_M1: begin
          if (completion || timeout_hit || !own_pending) begin
            state         <= IDLE;
            timeout_count <= 16'h0;
          end else begin
            timeout_count <= timeout_count + 16'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_memory_bus_arbiter.sv
// Bench for memory_bus_arbiter: a round-robin instance with an 8-cycle
// timeout behind a one-cycle registered memory stub, checked every cycle
// against a transaction-level model, plus a fixed-priority instance behind an
// always-acknowledging stub.

module tb_memory_bus_arbiter;

  localparam int TMO = 8;

  // clock / reset
  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  // round-robin DUT signals
  logic [31:0] m0_rw_address, m1_rw_address, m0_write_data, m1_write_data;
  logic [31:0] m0_read_data, m1_read_data;
  logic [3:0]  m0_write_strobe, m1_write_strobe;
  logic        m0_read_request, m1_read_request, m0_write_request, m1_write_request;
  logic        m0_read_response, m1_read_response, m0_write_response, m1_write_response;
  logic [31:0] s_rw_address, s_write_data;
  logic [31:0] s_read_data = 32'h0;
  logic [3:0]  s_write_strobe;
  logic        s_read_request, s_write_request;
  logic        s_read_response = 1'b0, s_write_response = 1'b0;
  logic        timeout_pulse;
  logic [1:0]  grant, debug_state;

  // fixed-priority DUT signals
  logic        fp_m0_rreq, fp_m1_rreq;
  logic [31:0] fp_m0_rdata, fp_m1_rdata, fp_s_addr, fp_s_wdata;
  logic        fp_m0_rresp, fp_m0_wresp, fp_m1_rresp, fp_m1_wresp;
  logic [3:0]  fp_s_strb;
  logic        fp_s_rreq, fp_s_wreq, fp_tp;
  logic        fp_s_rresp = 1'b0, fp_s_wresp = 1'b0;
  logic [1:0]  fp_grant, fp_dbg;

  memory_bus_arbiter #(.FIXED_PRIORITY(0), .TIMEOUT_CYCLES(TMO)) dut (
    .clock(clock), .reset(reset),
    .m0_rw_address(m0_rw_address), .m0_read_data(m0_read_data),
    .m0_read_request(m0_read_request), .m0_read_response(m0_read_response),
    .m0_write_data(m0_write_data), .m0_write_strobe(m0_write_strobe),
    .m0_write_request(m0_write_request), .m0_write_response(m0_write_response),
    .m1_rw_address(m1_rw_address), .m1_read_data(m1_read_data),
    .m1_read_request(m1_read_request), .m1_read_response(m1_read_response),
    .m1_write_data(m1_write_data), .m1_write_strobe(m1_write_strobe),
    .m1_write_request(m1_write_request), .m1_write_response(m1_write_response),
    .s_rw_address(s_rw_address), .s_write_data(s_write_data),
    .s_write_strobe(s_write_strobe), .s_read_request(s_read_request),
    .s_write_request(s_write_request), .s_read_data(s_read_data),
    .s_read_response(s_read_response), .s_write_response(s_write_response),
    .timeout_pulse(timeout_pulse), .grant(grant), .debug_state(debug_state)
  );

  memory_bus_arbiter #(.FIXED_PRIORITY(1), .TIMEOUT_CYCLES(TMO)) dut_fp (
    .clock(clock), .reset(reset),
    .m0_rw_address(32'h0), .m0_read_data(fp_m0_rdata),
    .m0_read_request(fp_m0_rreq), .m0_read_response(fp_m0_rresp),
    .m0_write_data(32'h0), .m0_write_strobe(4'h0),
    .m0_write_request(1'b0), .m0_write_response(fp_m0_wresp),
    .m1_rw_address(32'h4), .m1_read_data(fp_m1_rdata),
    .m1_read_request(fp_m1_rreq), .m1_read_response(fp_m1_rresp),
    .m1_write_data(32'h0), .m1_write_strobe(4'h0),
    .m1_write_request(1'b0), .m1_write_response(fp_m1_wresp),
    .s_rw_address(fp_s_addr), .s_write_data(fp_s_wdata),
    .s_write_strobe(fp_s_strb), .s_read_request(fp_s_rreq),
    .s_write_request(fp_s_wreq), .s_read_data(32'h0),
    .s_read_response(fp_s_rresp), .s_write_response(fp_s_wresp),
    .timeout_pulse(fp_tp), .grant(fp_grant), .debug_state(fp_dbg)
  );

  // memory stubs: one-cycle registered responses, byte-strobed writes
  logic [31:0] mem [0:63];
  logic        mem_stall;

  always @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < 64; i++) mem[i] <= 32'h0;
      mem[4] <= 32'hCAFEF00D;
    end
    if (mem_stall) begin
      s_read_response  <= 1'b0;
      s_write_response <= 1'b0;
    end else begin
      s_read_response  <= s_read_request;
      s_write_response <= s_write_request;
      s_read_data      <= mem[s_rw_address[7:2]];
      if (s_write_request && !reset)
        for (int b = 0; b < 4; b++)
          if (s_write_strobe[b]) mem[s_rw_address[7:2]][8*b +: 8] <= s_write_data[8*b +: 8];
    end
  end

  always @(posedge clock) begin
    fp_s_rresp <= fp_s_rreq;
    fp_s_wresp <= fp_s_wreq;
  end

  // scoreboard counters
  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // transaction-level model: owner (-1 none), cycles spent owning, last winner
  int mdl_owner = -1;
  int mdl_age   = 0;
  int mdl_last  = 1;
  logic fp_phase = 1'b0;
  int   fp_cnt   = 0;

  always @(negedge clock) begin : compare_proc
    logic rq, wq, comp, to, p0, p1;
    logic [1:0]  e_grant;
    logic        e_tp, e_srq, e_swq, e_rr, e_wr;
    logic [31:0] e_addr, e_wdata, e_rdata;
    logic [3:0]  e_strb;
    int pick;
    rq = 0; wq = 0; comp = 0; to = 0; e_grant = 2'b00; e_tp = 0; e_srq = 0; e_swq = 0;
    e_rr = 0; e_wr = 0; e_addr = 0; e_wdata = 0; e_rdata = 0; e_strb = 0;
    if (!reset && mdl_owner >= 0) begin
      rq      = (mdl_owner == 1) ? m1_read_request  : m0_read_request;
      wq      = (mdl_owner == 1) ? m1_write_request : m0_write_request;
      e_addr  = (mdl_owner == 1) ? m1_rw_address    : m0_rw_address;
      e_wdata = (mdl_owner == 1) ? m1_write_data    : m0_write_data;
      e_strb  = (mdl_owner == 1) ? m1_write_strobe  : m0_write_strobe;
      comp    = (rq && s_read_response) || (wq && s_write_response);
      to      = (rq || wq) && !comp && (mdl_age == TMO);
      e_grant = (mdl_owner == 1) ? 2'b10 : 2'b01;
      e_tp    = to;
      e_srq   = rq && !to;
      e_swq   = wq && !to;
      if (to) begin
        e_rr = rq;
        e_wr = wq;
      end else begin
        e_rr    = rq && s_read_response;
        e_wr    = wq && s_write_response;
        e_rdata = s_read_data;
      end
    end
    chk("grant", grant, e_grant);
    chk("timeout_pulse", timeout_pulse, e_tp);
    chk("s_read_request", s_read_request, e_srq);
    chk("s_write_request", s_write_request, e_swq);
    chk("s_rw_address", s_rw_address, e_addr);
    chk("s_write_data", s_write_data, e_wdata);
    chk("s_write_strobe", s_write_strobe, e_strb);
    chk("m0_read_response", m0_read_response, (mdl_owner == 0) ? e_rr : 1'b0);
    chk("m0_write_response", m0_write_response, (mdl_owner == 0) ? e_wr : 1'b0);
    chk("m0_read_data", m0_read_data, (mdl_owner == 0) ? e_rdata : 32'h0);
    chk("m1_read_response", m1_read_response, (mdl_owner == 1) ? e_rr : 1'b0);
    chk("m1_write_response", m1_write_response, (mdl_owner == 1) ? e_wr : 1'b0);
    chk("m1_read_data", m1_read_data, (mdl_owner == 1) ? e_rdata : 32'h0);

    if (reset) begin
      mdl_owner = -1; mdl_age = 0; mdl_last = 1;
    end else if (mdl_owner < 0) begin
      p0 = m0_read_request || m0_write_request;
      p1 = m1_read_request || m1_write_request;
      pick = -1;
      if (p0 && p1) pick = 1 - mdl_last;
      else if (p0)  pick = 0;
      else if (p1)  pick = 1;
      if (pick >= 0) begin
        mdl_owner = pick; mdl_last = pick; mdl_age = 0;
      end
    end else if (comp || to || !(rq || wq)) begin
      mdl_owner = -1;
    end else begin
      mdl_age++;
    end

    if (fp_phase && fp_m0_rreq) begin
      chk("fp_m1_blocked", fp_grant[1], 1'b0);
      if (fp_grant == 2'b01) fp_cnt++;
    end
  end

  // driver state
  logic        seen0 = 0, seen1 = 0, done0 = 0, done1 = 0, any0 = 0, any1 = 0, q1 = 0, tp_s = 0;
  logic [31:0] cap0 = 0, cap1 = 0;
  logic [1:0]  g_s = 0, g_prev = 0, fp_g_s = 0;
  int          order_q[$];
  int          exp_q[$];

  // one cycle: sample outputs mid-cycle, then release any request that was answered
  task automatic step();
    @(negedge clock);
    seen0 = m0_read_response | m0_write_response;
    seen1 = m1_read_response | m1_write_response;
    if (m0_read_response) cap0 = m0_read_data;
    if (m1_read_response) cap1 = m1_read_data;
    done0 = done0 | seen0;  done1 = done1 | seen1;
    any0  = any0 | seen0;   any1  = any1 | seen1;
    q1    = m1_read_response | m1_write_response | (m1_read_data != 32'h0);
    tp_s  = timeout_pulse;
    g_s   = grant;
    fp_g_s = fp_grant;
    if (g_s != 2'b00 && g_prev == 2'b00) order_q.push_back((g_s == 2'b01) ? 1 : 2);
    g_prev = g_s;
    @(posedge clock);
    #1;
    if (seen0) begin m0_read_request = 0; m0_write_request = 0; end
    if (seen1) begin m1_read_request = 0; m1_write_request = 0; end
  endtask

  task automatic issue(input int k, input bit wr, input logic [31:0] a,
                       input logic [31:0] d, input logic [3:0] st);
    if (k == 0) begin
      m0_rw_address = a; m0_write_data = d; m0_write_strobe = st;
      m0_read_request = !wr; m0_write_request = wr; done0 = 0;
    end else begin
      m1_rw_address = a; m1_write_data = d; m1_write_strobe = st;
      m1_read_request = !wr; m1_write_request = wr; done1 = 0;
    end
  endtask

  task automatic wait_both(input int limit);
    int n = 0;
    while (!(done0 && done1) && n < limit) begin
      step();
      n++;
    end
    chk("wait_both_bound", done0 && done1, 1'b1);
  endtask

  initial begin : watchdog
    #100000;
    n_fail++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin : main
    int n, busy_cnt, tp_cnt;
    reset = 1;
    mem_stall = 0;
    m0_rw_address = 0; m1_rw_address = 0; m0_write_data = 0; m1_write_data = 0;
    m0_write_strobe = 0; m1_write_strobe = 0;
    m0_read_request = 0; m1_read_request = 0; m0_write_request = 0; m1_write_request = 0;
    fp_m0_rreq = 0; fp_m1_rreq = 0;
    repeat (3) step();
    reset = 0;
    step();
    chk("reset_grant", g_s, 2'b00);

    // single m0 read: grant next cycle, data two cycles after request
    issue(0, 0, 32'h10, 32'h0, 4'h0);
    step(); chk("t1_idle_grant", g_s, 2'b00);
    step(); chk("t1_grant", g_s, 2'b01);
    step(); chk("t1_resp", seen0, 1'b1);
    chk("t1_data", cap0, 32'hCAFEF00D);
    chk("t1_m1_quiet", q1, 1'b0);
    step(); step();

    // ties after reset: m0 then m1, twice
    reset = 1; step(); step(); reset = 0;
    order_q.delete();
    issue(0, 0, 32'h10, 32'h0, 4'h0);
    issue(1, 0, 32'h00, 32'h0, 4'h0);
    wait_both(40);
    issue(0, 0, 32'h04, 32'h0, 4'h0);
    issue(1, 0, 32'h08, 32'h0, 4'h0);
    wait_both(40);

    // concurrent write (m0) and read (m1) of the same word
    issue(0, 1, 32'h20, 32'h12345678, 4'b0011);
    issue(1, 0, 32'h20, 32'h0, 4'h0);
    wait_both(40);
    chk("wr_then_rd", cap1, 32'h00005678);
    exp_q = '{1, 2, 1, 2, 1, 2};
    chk("order_len", order_q.size(), exp_q.size());
    foreach (exp_q[i]) chk("grant_order", (i < order_q.size()) ? order_q[i] : 0, exp_q[i]);
    step();

    // owner drops request mid-access: back to idle, no response
    any1 = 0;
    issue(1, 0, 32'h10, 32'h0, 4'h0);
    n = 0;
    while (g_s != 2'b10 && n < 6) begin step(); n++; end
    chk("drop_granted", g_s, 2'b10);
    m1_read_request = 0;
    step(); step();
    chk("drop_idle", g_s, 2'b00);
    chk("drop_no_resp", any1, 1'b0);

    // memory never answers: forced completion after TMO busy cycles
    mem_stall = 1;
    busy_cnt = 0; tp_cnt = 0; n = 0;
    issue(1, 1, 32'h30, 32'hA5A5A5A5, 4'hF);
    while (!done1 && n < 30) begin
      step();
      n++;
      if (g_s == 2'b10 && !tp_s) busy_cnt++;
      if (tp_s) tp_cnt++;
    end
    chk("tmo_wresp", done1, 1'b1);
    chk("tmo_busy_cycles", busy_cnt, TMO);
    chk("tmo_pulse_count", tp_cnt, 1);
    step();
    chk("tmo_idle", g_s, 2'b00);
    chk("tmo_pulse_done", tp_s, 1'b0);
    mem_stall = 0;
    step();

    // reset during BUSY_M0 aborts the access; request held through reset
    any0 = 0;
    issue(0, 0, 32'h10, 32'h0, 4'h0);
    step();
    reset = 1;
    step(); step();
    chk("rst_no_resp", any0, 1'b0);
    chk("rst_grant", g_s, 2'b00);
    reset = 0;
    step(); chk("rst_idle_first", g_s, 2'b00);
    step(); chk("rst_regrant", g_s, 2'b01);
    step(); chk("rst_resp", seen0, 1'b1);
    chk("rst_data", cap0, 32'hCAFEF00D);
    step();

    // fixed priority: m1 starved while m0 keeps requesting
    fp_phase = 1;
    fp_m0_rreq = 1; fp_m1_rreq = 1;
    repeat (30) step();
    fp_m0_rreq = 0;
    fp_phase = 0;
    chk("fp_m0_grants", fp_cnt, 20);
    n = 0;
    while (fp_g_s != 2'b10 && n < 6) begin step(); n++; end
    chk("fp_m1_served", fp_g_s, 2'b10);
    fp_m1_rreq = 0;
    step(); step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/memory_bus_arbiter.md
MEMORY_BUS_ARBITER -- requirements
Module: memory_bus_arbiter

Interface
REQ-001 Parameter: FIXED_PRIORITY, 0, 0 = round-robin, 1 = manager 0 always wins.
REQ-002 Parameter: TIMEOUT_CYCLES, 255, BUSY cycles allowed before forced completion; range 2..65535.
REQ-003 clock  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-high.
REQ-005 m0_rw_address/m1_rw_address  input  32  manager address.
REQ-006 m0_read_data/m1_read_data  output  32  read data to manager.
REQ-007 m0_read_request/m1_read_request  input  1  manager read request.
REQ-008 m0_read_response/m1_read_response  output  1  read completion to manager.
REQ-009 m0_write_data/m1_write_data  input  32  manager write data.
REQ-010 m0_write_strobe/m1_write_strobe  input  4  byte enables.
REQ-011 m0_write_request/m1_write_request  input  1  manager write request.
REQ-012 m0_write_response/m1_write_response  output  1  write completion to manager.
REQ-013 s_rw_address, s_write_data (32), s_write_strobe (4), s_read_request, s_write_request (1)  output  forwarded to memory.
REQ-014 s_read_data (32), s_read_response, s_write_response (1)  input  from memory.
REQ-015 timeout_pulse  output  1  one-cycle pulse on forced completion.
REQ-016 grant  output  2  one-hot current owner (01 = m0, 10 = m1, 00 = none).

Function
REQ-017 States SHALL be IDLE, BUSY_M0, BUSY_M1.
REQ-018 Manager pending = read_request | write_request; manager holds request, address, data, strobe stable until it samples its response high.
REQ-019 IDLE, no pending: stay IDLE.
REQ-020 IDLE, one pending: next state BUSY of that manager.
REQ-021 IDLE, both pending, FIXED_PRIORITY=1: BUSY_M0.
REQ-022 IDLE, both pending, FIXED_PRIORITY=0: grant manager not in last_grant register; last_grant updated on each grant.
REQ-023 In IDLE all s_* request outputs SHALL be 0, s_rw_address/s_write_data/s_write_strobe 0, all manager responses 0, s_*_response ignored.
REQ-024 In BUSY_Mx, s_* outputs SHALL combinationally equal manager x's signals; s_read_data and s_*_response routed combinationally to manager x only; other manager sees responses 0, read_data 0.
REQ-025 Completion = (s_read_request & s_read_response) | (s_write_request & s_write_response) in BUSY; next state IDLE.
REQ-026 Mandatory IDLE cycle after every completion (absorbs memory's registered response); no back-to-back BUSY.
REQ-027 Latency with one-cycle memory: request at cycle N, forwarded N+1, response N+2, IDLE N+3, next grant earliest N+4.
REQ-028 16-bit timeout counter cleared on entry to BUSY, incremented each BUSY cycle without completion.
REQ-029 Counter reaching TIMEOUT_CYCLES: assert owner's pending response(s) for that cycle, read_data 0, s_* requests 0, timeout_pulse 1, next state IDLE.
REQ-030 Completion and timeout in same cycle: completion wins, no timeout_pulse, real data returned.
REQ-031 Owner drops request mid-BUSY (protocol violation): return to IDLE next cycle, no response generated.

Reset
REQ-032 Reset SHALL force IDLE, last_grant = m1 (so m0 wins first tie), counter 0, timeout_pulse 0, grant 00.
REQ-033 During reset all outputs 0; reset mid-BUSY aborts the access without response; first grant possible cycle after reset deasserts.

Verification
REQ-034 m0 read 0x00000010 alone, memory holds 0xCAFEF00D -> grant 01 next cycle, m0_read_response + data 0xCAFEF00D two cycles after request, m1 outputs 0.
REQ-035 Both request same cycle after reset, round-robin -> m0 served first, IDLE cycle, m1 served; repeated ties alternate m0, m1, m0.
REQ-036 FIXED_PRIORITY=1, both continuously requesting -> m1 never granted while m0 pending.
REQ-037 Memory stub never responds, TIMEOUT_CYCLES=8, m1 write -> after 8 BUSY cycles m1_write_response 1, timeout_pulse 1 one cycle, state IDLE.
REQ-038 m0 write 0x12345678 strobe 4'b0011 to 0x20 while m1 reads 0x20 -> write completes first, m1 reads 0x00005678 when memory initialised to 0.
REQ-039 Reset asserted in BUSY_M0 before response -> no m0 response, grant 00, normal operation after release.
